// File: rtl/mem_req_arbiter.sv
// N-port request arbiter onto a single-ported RAM with a read/write/busy handshake.
// Fixed-priority or round-robin grant, one-cycle hit/err pulse per transaction, busy timeout abort.
module mem_req_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RAM_ADDR_W = 12,
  parameter int ADDR_SHIFT = 0,
  parameter int RR_MODE    = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_read,
  input  logic [N_PORTS-1:0]         req_write,
  input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
  input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
  input  logic [N_PORTS*4-1:0]       req_sel,
  output logic [N_PORTS-1:0]         hit,
  output logic [N_PORTS-1:0]         err,
  output logic [DATA_W-1:0]          rdata,
  output logic                       arb_busy,
  output logic                       read_i,
  output logic                       write_i,
  output logic [RAM_ADDR_W-1:0]      adr_i,
  output logic [DATA_W-1:0]          cpu_dat_i,
  output logic [3:0]                 sel_i,
  input  logic                       busy_o,
  input  logic [DATA_W-1:0]          cpu_dat_o
);

  localparam int GNT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [GNT_W-1:0]    grant_q, grant_d;
  logic [GNT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N_PORTS-1:0]  pending;
  logic [GNT_W-1:0]    win_idx;
  logic                win_found;

  assign pending = req_read | req_write;

  // Scan starts at rr_ptr in round-robin mode, at port 0 otherwise.
  always_comb begin
    int               idx;
    logic [GNT_W-1:0] idx_b;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_b     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx   = (RR_MODE != 0) ? (int'(rr_ptr_q) + i) % N_PORTS : i;
      idx_b = GNT_W'(idx);
      if (!win_found && pending[idx_b]) begin
        win_found = 1'b1;
        win_idx   = idx_b;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    hit       = '0;
    err       = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    adr_i     = '0;
    cpu_dat_i = '0;
    sel_i     = '0;
    arb_busy  = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d  = win_idx;
          rr_ptr_d = (win_idx == GNT_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
          addr_d   = req_addr[win_idx*ADDR_W +: ADDR_W];
          wdata_d  = req_wdata[win_idx*DATA_W +: DATA_W];
          sel_d    = req_sel[win_idx*4 +: 4];
          wr_d     = req_write[win_idx];
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        read_i    = !wr_q;
        write_i   = wr_q;
        adr_i     = RAM_ADDR_W'(addr_q >> ADDR_SHIFT);
        cpu_dat_i = wdata_q;
        sel_i     = sel_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        adr_i     = RAM_ADDR_W'(addr_q >> ADDR_SHIFT);
        cpu_dat_i = wdata_q;
        sel_i     = sel_q;
        if (!busy_o) begin
          if (!wr_q) rdata_d = cpu_dat_o;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) state_d = S_ABORT;
        end
      end
      S_DONE: begin
        hit[grant_q] = 1'b1;
        state_d      = S_IDLE;
      end
      S_ABORT: begin
        err[grant_q] = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
